// File: rtl/sccb_byte_ctrl.sv
// Byte-level SCCB/I2C sequencer: breaks one byte transaction (START, 8 data bits,
// acknowledge phase, STOP) into single-bit commands for the bit controller.
module sccb_byte_ctrl #(
  parameter logic [3:0] CMD_NOP   = 4'b0000,
  parameter logic [3:0] CMD_START = 4'b0001,
  parameter logic [3:0] CMD_STOP  = 4'b0010,
  parameter logic [3:0] CMD_READ  = 4'b0100,
  parameter logic [3:0] CMD_WRITE = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       busy,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  logic [2:0] state, state_nxt;
  logic [7:0] sr, sr_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [3:0] cmd_nxt;
  logic       ack_out_nxt, cmd_ack_nxt, txd_nxt;
  logic       go;

  // cmd_ack masks go so the still-held request cannot restart in the completion cycle
  assign go   = (read | write | stop) & ~cmd_ack;
  assign dout = sr;
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    cnt_nxt     = cnt;
    cmd_nxt     = core_cmd;
    ack_out_nxt = ack_out;
    cmd_ack_nxt = 1'b0;
    txd_nxt     = 1'b0;
    case (state)
      ST_IDLE: if (go) begin
        sr_nxt  = din;
        cnt_nxt = 3'd7;
        if (start)      begin state_nxt = ST_START; cmd_nxt = CMD_START; end
        else if (read)  begin state_nxt = ST_READ;  cmd_nxt = CMD_READ;  end
        else if (write) begin state_nxt = ST_WRITE; cmd_nxt = CMD_WRITE; end
        else            begin state_nxt = ST_STOP;  cmd_nxt = CMD_STOP;  end
      end
      ST_START: if (core_ack) begin
        if (read) begin state_nxt = ST_READ;  cmd_nxt = CMD_READ;  end
        else      begin state_nxt = ST_WRITE; cmd_nxt = CMD_WRITE; end
      end
      ST_READ, ST_WRITE: if (core_ack) begin
        sr_nxt  = {sr[6:0], core_rxd};
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd0) begin
          state_nxt = ST_ACK;
          // master drives ack_in after a read, samples the slave ack after a write
          cmd_nxt   = read ? CMD_WRITE : CMD_READ;
        end
      end
      ST_ACK: if (core_ack) begin
        ack_out_nxt = core_rxd;
        if (stop) begin
          state_nxt = ST_STOP;
          cmd_nxt   = CMD_STOP;
        end else begin
          state_nxt   = ST_IDLE;
          cmd_nxt     = CMD_NOP;
          cmd_ack_nxt = 1'b1;
        end
      end
      ST_STOP: if (core_ack) begin
        state_nxt   = ST_IDLE;
        cmd_nxt     = CMD_NOP;
        cmd_ack_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        cmd_nxt   = CMD_NOP;
      end
    endcase
    // txd follows the upcoming state so it is valid as soon as the command appears
    case (state_nxt)
      ST_WRITE: txd_nxt = sr_nxt[7];
      ST_ACK:   txd_nxt = ack_in;
      default:  txd_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sr       <= 8'h00;
      cnt      <= 3'd0;
      core_cmd <= CMD_NOP;
      core_txd <= 1'b0;
      cmd_ack  <= 1'b0;
      ack_out  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      cnt      <= cnt_nxt;
      core_cmd <= cmd_nxt;
      core_txd <= txd_nxt;
      cmd_ack  <= cmd_ack_nxt;
      ack_out  <= ack_out_nxt;
    end
  end

endmodule

// File: tb/tb_sccb_byte_ctrl.sv
// Randomized bench for sccb_byte_ctrl: a bit-controller model with random latency
// logs every acked command; each transaction is compared against a phase-list model.
module tb_sccb_byte_ctrl;
  localparam logic [3:0] NOP = 4'b0000, STA = 4'b0001, STO = 4'b0010,
                         RD  = 4'b0100, WR  = 4'b1000;

  logic       clk, rst;
  logic       start, stop, read, write, ack_in;
  logic [7:0] din, dout;
  logic       cmd_ack, ack_out, busy, core_txd, core_ack, core_rxd;
  logic [3:0] core_cmd;

  int n_chk = 0, n_err = 0;
  logic exp_ack_out = 1'b0;

  sccb_byte_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout),
    .busy(busy), .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
    .core_rxd(core_rxd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bit-controller model: acks each command after a random delay, returns rxd from rxq
  logic [4:0] cmd_log[$];
  logic       rxq[$];
  int         m_cnt, m_lat;
  always @(posedge clk or posedge rst) begin
    logic b;
    if (rst) begin
      core_ack <= 1'b0;
      core_rxd <= 1'b0;
      m_cnt    <= 0;
      m_lat    <= 4;
    end else begin
      core_ack <= 1'b0;
      if (core_cmd != NOP && !core_ack) begin
        if (m_cnt >= m_lat) begin
          b = (rxq.size() > 0) ? rxq.pop_front() : 1'b0;
          core_ack <= 1'b1;
          core_rxd <= b;
          m_cnt    <= 0;
          m_lat    <= int'($urandom_range(1, 5));
          cmd_log.push_back({core_cmd, core_txd});
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drop();
    start = 0; stop = 0; read = 0; write = 0; ack_in = 0; din = 8'h00;
  endtask

  // abort_at > 0: assert rst once that many commands have been acked
  task automatic run_txn(input logic s, p, r, w, ai, input logic [7:0] d,
                         input logic [7:0] rx, input logic sa, input int abort_at);
    logic [4:0] exp[$];
    logic [7:0] exp_dout;
    logic       data;
    int         cyc;
    data = s | r | w;
    rxq.delete();
    if (s) begin exp.push_back({STA, 1'b0}); rxq.push_back(1'($urandom)); end
    if (data) begin
      for (int i = 7; i >= 0; i--) begin
        exp.push_back(r ? {RD, 1'b0} : {WR, d[i]});
        rxq.push_back(rx[i]);
      end
      exp.push_back({(r ? WR : RD), ai});
      rxq.push_back(sa);
    end
    if (p) begin exp.push_back({STO, 1'b0}); rxq.push_back(1'($urandom)); end
    exp_dout = data ? rx : d;
    cmd_log.delete();

    @(negedge clk);
    start = s; stop = p; read = r; write = w; ack_in = ai; din = d;
    cyc = 0;
    if (abort_at > 0) begin
      while (cmd_log.size() < abort_at && cyc < 2000) begin @(negedge clk); cyc++; end
      chk("abort_reached", 32'(cyc < 2000), 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_cmd", core_cmd, NOP);
      chk("abort_cmd_ack", cmd_ack, 0);
      chk("abort_txd", core_txd, 0);
      chk("abort_ack_out", ack_out, 0);
      exp_ack_out = 1'b0;
      @(negedge clk);
      drop();
      rst = 1'b0;
      rxq.delete();
      return;
    end
    while (!cmd_ack && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("cmd_ack_seen", cmd_ack, 1);
    if (data) exp_ack_out = sa;
    chk("dout", dout, exp_dout);
    chk("ack_out", ack_out, exp_ack_out);
    chk("cmd_nop_at_done", core_cmd, NOP);
    // inputs still held across this edge: go must stay masked
    @(posedge clk);
    #1;
    drop();
    chk("ack_pulse", cmd_ack, 0);
    chk("idle_after", busy, 0);
    chk("nop_after", core_cmd, NOP);
    chk("seq_len", cmd_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cmd_log.size(); i++)
      chk($sformatf("seq%0d", i), cmd_log[i], exp[i]);
  endtask

  initial begin
    rst = 1'b1;
    drop();
    repeat (2) @(negedge clk);
    chk("rst_cmd", core_cmd, NOP);
    chk("rst_txd", core_txd, 0);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_ack_out", ack_out, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // start alone is not a transaction
    start = 1'b1;
    repeat (6) @(negedge clk);
    chk("start_only_busy", busy, 0);
    chk("start_only_cmd", core_cmd, NOP);
    drop();

    //       s  p  r  w  ai din    rx     sa abort
    run_txn(1, 0, 0, 1, 0, 8'h42, 8'h42, 0, 0);
    run_txn(0, 1, 1, 0, 1, 8'h00, 8'hA5, 0, 0);
    run_txn(0, 0, 0, 1, 0, 8'hFF, 8'hFF, 1, 0);
    run_txn(0, 1, 0, 0, 0, 8'h5E, 8'h00, 0, 0);
    run_txn(0, 0, 0, 1, 0, 8'h96, 8'h96, 0, 4);
    run_txn(0, 0, 0, 1, 0, 8'h3C, 8'h3C, 0, 0);
    // back-to-back and read-over-write priority
    run_txn(0, 0, 0, 1, 0, 8'h81, 8'h7E, 1, 0);
    run_txn(0, 0, 0, 1, 0, 8'h18, 8'h18, 0, 0);
    run_txn(1, 1, 1, 1, 0, 8'hC3, 8'h3A, 1, 0);
    run_txn(1, 1, 0, 0, 0, 8'h69, 8'h69, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic s, p, r, w;
      s = 1'($urandom); p = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
      if (!(r | w | p)) p = 1'b1;
      run_txn(s, p, r, w, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
